// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter.
//   arb_state_e : 2-bit FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   DEF_*       : default widths / latency
//   rr_next     : round-robin candidate index helper
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_MEM_LATENCY = 1;

  // k-th candidate after the last granted master, wrapping at n
  function automatic int rr_next(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request-port bundle between the bus masters and the arbiter.
//   m_req/m_write_en : per-master request and direction
//   m_addr/m_select/m_data_i : per-master command fields, packed so master i
//                      occupies [i*W +: W] of the flattened vector
//   m_ack            : one-hot completion pulse
//   m_data_o         : shared read data, valid with m_ack
// Modports: slave = arbiter side, master = requester side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) ();
  localparam int SEL_W = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]                 m_req;
  logic [NUM_MASTERS-1:0]                 m_write_en;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS-1:0][SEL_W-1:0]      m_select;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_data_i;
  logic [NUM_MASTERS-1:0]                 m_ack;
  logic [DATA_WIDTH-1:0]                  m_data_o;

  modport slave (
    input  m_req, m_write_en, m_addr, m_select, m_data_i,
    output m_ack, m_data_o
  );

  modport master (
    output m_req, m_write_en, m_addr, m_select, m_data_i,
    input  m_ack, m_data_o
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin grant.
//   req     : request vector
//   rr_last : index of the most recently granted master
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : binary index of the granted master
//   gnt_vld : any request present
// Search starts at rr_last+1 and wraps, so the last winner has lowest priority.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   gnt_vld
);

  int cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = rr_next(int'(rr_last), k, NUM_MASTERS);
      if (!gnt_vld && req[cand]) begin
        gnt_vld   = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between
// NUM_MASTERS request ports.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   mif           : master request/ack bundle (slave modport)
//   ram_en        : one-cycle access strobe (ISSUE state)
//   ram_write_en, ram_addr, ram_select, ram_data_o : command to RAM,
//                   held in command registers so they are stable in ISSUE
//   ram_data_i    : RAM read data, valid MEM_LATENCY cycles after ram_en
// One access in flight: IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_arbiter_if.slave            mif,
  output logic                    ram_en,
  output logic                    ram_write_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH/8-1:0] ram_select,
  output logic [DATA_WIDTH-1:0]   ram_data_o,
  input  logic [DATA_WIDTH-1:0]   ram_data_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_e state, state_nxt;

  logic [NUM_MASTERS-1:0] gnt_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   any_req;

  logic [IDX_W-1:0]       rr_last;
  logic [IDX_W-1:0]       cmd_idx;
  logic [NUM_MASTERS-1:0] cmd_oh;
  logic                   cmd_we;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [SEL_W-1:0]       cmd_sel;
  logic [DATA_WIDTH-1:0]  cmd_data;
  logic [CNT_W-1:0]       lat_cnt;
  logic [DATA_WIDTH-1:0]  rdata_q;

  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_rr (
    .req     (mif.m_req),
    .rr_last (rr_last),
    .gnt     (gnt_oh),
    .gnt_idx (win_idx),
    .gnt_vld (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = cmd_we ? S_RESP : S_WAIT;
      S_WAIT:  if (lat_cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command capture, latency count and read-data register. The pointer only
  // moves in RESP, so an access aborted by reset never changes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last  <= IDX_W'(NUM_MASTERS - 1);
      cmd_idx  <= '0;
      cmd_oh   <= '0;
      cmd_we   <= 1'b0;
      cmd_addr <= '0;
      cmd_sel  <= '0;
      cmd_data <= '0;
      lat_cnt  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          cmd_idx  <= win_idx;
          cmd_oh   <= gnt_oh;
          cmd_we   <= mif.m_write_en[win_idx];
          cmd_addr <= mif.m_addr[win_idx];
          cmd_sel  <= mif.m_select[win_idx];
          cmd_data <= mif.m_data_i[win_idx];
        end
        S_ISSUE: if (!cmd_we) lat_cnt <= CNT_W'(MEM_LATENCY - 1);
        S_WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
          else               rdata_q <= ram_data_i;
        end
        S_RESP: rr_last <= cmd_idx;
        default: ;
      endcase
    end
  end

  assign ram_en       = (state == S_ISSUE);
  assign ram_write_en = cmd_we;
  assign ram_addr     = cmd_addr;
  assign ram_select   = cmd_sel;
  assign ram_data_o   = cmd_data;

  assign mif.m_ack    = (state == S_RESP) ? cmd_oh : '0;
  assign mif.m_data_o = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (2 masters / latency 1, 4 masters / latency 4),
// each with a behavioural RAM. Expected completions are queued when a request
// is driven and checked when ram_en / m_ack appear.
module tb_mem_arbiter;

  localparam int NM_A = 2, LAT_A = 1;
  localparam int NM_B = 4, LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_v;

  // stimulus, sized for the 4-master instance
  logic [1:0][3:0]       req_v, we_v;
  logic [1:0][3:0][31:0] addr_v, wd_v;
  logic [1:0][3:0][3:0]  sel_v;

  // observed DUT outputs
  logic [1:0]       ren_v, rwe_v;
  logic [1:0][31:0] raddr_v, rwd_v, rrd_v, dout_v;
  logic [1:0][3:0]  rsel_v, ack_v;

  mem_arbiter_if #(.NUM_MASTERS(NM_A), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  mem_arbiter_if #(.NUM_MASTERS(NM_B), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  assign ifa.m_req      = req_v[0][1:0];
  assign ifa.m_write_en = we_v[0][1:0];
  assign ifa.m_addr     = addr_v[0][1:0];
  assign ifa.m_select   = sel_v[0][1:0];
  assign ifa.m_data_i   = wd_v[0][1:0];
  assign ack_v[0]       = {2'b00, ifa.m_ack};
  assign dout_v[0]      = ifa.m_data_o;

  assign ifb.m_req      = req_v[1];
  assign ifb.m_write_en = we_v[1];
  assign ifb.m_addr     = addr_v[1];
  assign ifb.m_select   = sel_v[1];
  assign ifb.m_data_i   = wd_v[1];
  assign ack_v[1]       = ifb.m_ack;
  assign dout_v[1]      = ifb.m_data_o;

  mem_arbiter #(.NUM_MASTERS(NM_A), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst_v[0]), .mif(ifa),
    .ram_en(ren_v[0]), .ram_write_en(rwe_v[0]), .ram_addr(raddr_v[0]),
    .ram_select(rsel_v[0]), .ram_data_o(rwd_v[0]), .ram_data_i(rrd_v[0])
  );

  mem_arbiter #(.NUM_MASTERS(NM_B), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst_v[1]), .mif(ifb),
    .ram_en(ren_v[1]), .ram_write_en(rwe_v[1]), .ram_addr(raddr_v[1]),
    .ram_select(rsel_v[1]), .ram_data_o(rwd_v[1]), .ram_data_i(rrd_v[1])
  );

  // Behavioural RAMs: byte-enabled write, read data delayed through a valid
  // pipeline; outside the valid slot the bus carries a cycle-stamped pattern
  // so an early or late capture shows up as wrong data.
  logic [31:0] mem [2][256];
  logic [7:0]  pv [2] = '{default: '0};
  logic [31:0] pd [2][8];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ren_v[d] && rwe_v[d])
        for (int b = 0; b < 4; b++)
          if (rsel_v[d][b]) mem[d][raddr_v[d][9:2]][8*b +: 8] <= rwd_v[d][8*b +: 8];
      pv[d]    <= {pv[d][6:0], ren_v[d] & ~rwe_v[d]};
      pd[d][0] <= mem[d][raddr_v[d][9:2]];
      for (int s = 1; s < 8; s++) pd[d][s] <= pd[d][s-1];
    end
  end

  logic [31:0] garb;
  assign garb     = {16'hBAD0, 16'(cyc)};
  assign rrd_v[0] = pv[0][LAT_A-1] ? pd[0][LAT_A-1] : garb;
  assign rrd_v[1] = pv[1][LAT_B-1] ? pd[1][LAT_B-1] : garb;

  // ---------------------------------------------------------------- checking
  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          mst;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [31:0] ref_mem [2][256];
  int          rr_ptr [2];
  int          en_cnt [2];
  int          en_cyc [2];
  logic [31:0] last_rd [2];

  function automatic int lat(input int d);
    return d ? LAT_B : LAT_A;
  endfunction

  function automatic int sb_size(input int d);
    return d ? q1.size() : q0.size();
  endfunction

  function automatic exp_t sb_front(input int d);
    return d ? q1[0] : q0[0];
  endfunction

  function automatic exp_t sb_pop(input int d);
    return d ? q1.pop_front() : q0.pop_front();
  endfunction

  function automatic void push_op(input int d, input int m, input logic we,
                                  input logic [31:0] a, input logic [3:0] s,
                                  input logic [31:0] w);
    exp_t e;
    e.mst = m; e.we = we; e.addr = a; e.sel = s;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[d][a[9:2]][8*b +: 8] = w[8*b +: 8];
      e.data = w;
    end else begin
      e.data = ref_mem[d][a[9:2]];
    end
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int rr_pick(input int d, input logic [3:0] mask);
    int n;
    int c;
    n = d ? NM_B : NM_A;
    for (int k = 1; k <= n; k++) begin
      c = (rr_ptr[d] + k) % n;
      if (mask[c]) return c;
    end
    return 0;
  endfunction

  function automatic void set_fields(input int d, input int m, input logic we,
                                     input logic [31:0] a, input logic [3:0] s,
                                     input logic [31:0] w);
    we_v[d][m]   = we;
    addr_v[d][m] = a;
    sel_v[d][m]  = s;
    wd_v[d][m]   = w;
  endfunction

  function automatic logic [31:0] baddr(input int m, input int k);
    return 32'h200 + 32'(m * 16 + k * 4);
  endfunction

  function automatic logic [31:0] bdata(input int d, input int m, input int k);
    return 32'h5A00_0000 + 32'(d * 65536 + m * 256 + k);
  endfunction

  // Monitor: reset sampled at posedge, outputs at the following negedge.
  task automatic monitor();
    logic [1:0] rs;
    exp_t e;
    forever begin
      @(posedge clk);
      rs = rst_v;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rs[d]) begin
          en_cnt[d]  = 0;
          last_rd[d] = '0;
        end else begin
          if (ren_v[d]) begin
            en_cnt[d]++;
            en_cyc[d] = cyc;
            if (sb_size(d) == 0) chk("unexp_en", 32'(ren_v[d]), 0);
            else begin
              e = sb_front(d);
              chk("ram_we",   32'(rwe_v[d]),  32'(e.we));
              chk("ram_addr", raddr_v[d],     e.addr);
              chk("ram_sel",  32'(rsel_v[d]), 32'(e.sel));
              if (e.we) chk("ram_wdata", rwd_v[d], e.data);
            end
          end
          if (ack_v[d] != '0) begin
            if (sb_size(d) == 0) chk("unexp_ack", 32'(ack_v[d]), 0);
            else begin
              e = sb_pop(d);
              chk("ack_mst",   32'(ack_v[d]), 32'(1) << e.mst);
              chk("en_cnt",    en_cnt[d], 1);
              chk("en_to_ack", cyc - en_cyc[d], e.we ? 1 : 1 + lat(d));
              if (e.we) chk("wr_keep_dout", dout_v[d], last_rd[d]);
              else begin
                chk("rd_data", dout_v[d], e.data);
                last_rd[d] = e.data;
              end
            end
            en_cnt[d] = 0;
          end
        end
      end
    end
  endtask

  // --------------------------------------------------------------- stimulus
  task automatic chk_rst(input int d);
    chk("rst_ram_en", 32'(ren_v[d]),   0);
    chk("rst_ram_we", 32'(rwe_v[d]),   0);
    chk("rst_ack",    32'(ack_v[d]),   0);
    chk("rst_dout",   dout_v[d],       0);
    chk("rst_addr",   raddr_v[d],      0);
    chk("rst_sel",    32'(rsel_v[d]),  0);
    chk("rst_wdata",  rwd_v[d],        0);
  endtask

  // Single master access from an idle arbiter; T is the cycle req is seen.
  task automatic access(input int d, input int m, input logic we,
                        input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    int t0;
    bit seen;
    @(negedge clk);
    set_fields(d, m, we, a, s, w);
    req_v[d][m] = 1'b1;
    push_op(d, m, we, a, s, w);
    rr_ptr[d] = m;
    t0   = cyc;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack_v[d][m]) seen = 1;
    end
    if (!seen) chk("ack_timeout", 32'(seen), 1);
    else begin
      chk("ack_lat", cyc - t0, we ? 2 : 2 + lat(d));
      chk("en_lat",  en_cyc[d] - t0, 1);
    end
    req_v[d][m] = 1'b0;
  endtask

  // Masters in mask each issue nops back-to-back accesses, holding req high.
  task automatic burst(input int d, input logic [3:0] mask, input int nops, input logic we);
    int left [4];
    int opk [4];
    int total, done, prev, pick, m;
    logic [3:0] pend;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      left[i] = mask[i] ? nops : 0;
      opk[i]  = 0;
      total  += left[i];
    end
    for (int n = 0; n < total; n++) begin
      for (int i = 0; i < 4; i++) pend[i] = (left[i] > 0);
      pick = rr_pick(d, pend);
      push_op(d, pick, we, baddr(pick, nops - left[pick]), 4'hF,
              bdata(d, pick, nops - left[pick]));
      rr_ptr[d] = pick;
      left[pick]--;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (mask[i]) begin
        set_fields(d, i, we, baddr(i, 0), 4'hF, bdata(d, i, 0));
        req_v[d][i] = 1'b1;
      end
    done = 0;
    prev = -1;
    for (int t = 0; t < 80 * total && done < total; t++) begin
      @(negedge clk);
      if ((ack_v[d] & mask) != '0) begin
        m = 0;
        for (int i = 3; i >= 0; i--) if (ack_v[d][i]) m = i;
        if (prev >= 0) chk("ack_gap", cyc - prev, we ? 3 : lat(d) + 3);
        prev = cyc;
        done++;
        opk[m]++;
        if (opk[m] < nops) set_fields(d, m, we, baddr(m, opk[m]), 4'hF, bdata(d, m, opk[m]));
        else               req_v[d][m] = 1'b0;
      end
    end
    if (done < total) begin
      chk("burst_timeout", done, total);
      req_v[d] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_v  = 2'b11;
    req_v  = '0; we_v = '0; addr_v = '0; wd_v = '0; sel_v = '0;
    rr_ptr = '{NM_A - 1, NM_B - 1};
    en_cnt = '{0, 0};
    en_cyc = '{0, 0};
    last_rd = '{32'h0, 32'h0};
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst_v = 2'b00;
    chk_rst(0);
    chk_rst(1);

    // ---- 2 masters, latency 1
    access(0, 1, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
    access(0, 0, 1'b0, 32'h100, 4'hF, 32'h0);           // single read
    access(0, 1, 1'b1, 32'h008, 4'hF, 32'hAABB_CCDD);
    access(0, 1, 1'b1, 32'h008, 4'b0011, 32'h1122_3344); // byte enables
    access(0, 0, 1'b1, 32'h008, 4'b0000, 32'hFFFF_FFFF); // no bytes written
    access(0, 1, 1'b0, 32'h008, 4'hF, 32'h0);           // expect AABB3344
    burst(0, 4'b0011, 2, 1'b1);                          // grants 0,1,0,1
    burst(0, 4'b0011, 2, 1'b0);

    // ---- 4 masters, latency 4
    access(1, 2, 1'b1, 32'h020, 4'hF, 32'hCAFE_F00D);
    access(1, 2, 1'b0, 32'h020, 4'hF, 32'h0);           // latency sweep
    access(1, 3, 1'b1, 32'h030, 4'hF, 32'h1234_5678);
    burst(1, 4'b1010, 1, 1'b1);                          // after 3: grant 1 then 3
    burst(1, 4'b1010, 1, 1'b0);
    access(1, 2, 1'b0, 32'h030, 4'hF, 32'h0);           // last grant = 2

    // reset while a read by master 1 sits in WAIT
    @(negedge clk);
    set_fields(1, 1, 1'b0, 32'h020, 4'hF, 32'h0);
    req_v[1][1] = 1'b1;
    push_op(1, 1, 1'b0, 32'h020, 4'hF, 32'h0);
    t0 = cyc;
    repeat (3) @(negedge clk);
    chk("pre_rst_in_wait", 32'(cyc - t0), 3);
    rst_v[1]    = 1'b1;
    req_v[1][1] = 1'b0;
    q1.delete();
    @(negedge clk);
    rst_v[1]  = 1'b0;
    rr_ptr[1] = NM_B - 1;
    chk_rst(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_ack_after_rst", 32'(ack_v[1]), 0);
    end
    burst(1, 4'b1001, 1, 1'b1);                          // master 0 wins after reset
    burst(1, 4'b1001, 1, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_drained_a", q0.size(), 0);
    chk("sb_drained_b", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised memory arbiter that lets `NUM_MASTERS` request ports (instruction fetch, data load/store, later a DMA or debug port) share one synchronous single-port RAM. It sits in the SoC top between the CPU core's memory ports and the unified RAM, replacing direct point-to-point ROM/RAM wiring. It adds round-robin arbitration, a req/ack handshake and a configurable fixed memory read latency.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of request ports, 2..8.
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data width; a multiple of 8.
- `MEM_LATENCY`, 1: cycles from the `ram_en` cycle to valid `ram_data_i`, 1..8.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m_req` in NUM_MASTERS: per-master request, held until ack.
- `m_write_en` in NUM_MASTERS: 1 = write, 0 = read.
- `m_addr` in NUM_MASTERS*ADDR_WIDTH: flattened; master i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `m_select` in NUM_MASTERS*(DATA_WIDTH/8): byte enables, flattened the same way.
- `m_data_i` in NUM_MASTERS*DATA_WIDTH: write data.
- `m_ack` out NUM_MASTERS: one-cycle completion pulse, one-hot or zero.
- `m_data_o` out DATA_WIDTH: read data, shared by all masters; valid only while the matching `m_ack` is high.
- `ram_en` out 1: memory access strobe.
- `ram_write_en` out 1: memory write enable.
- `ram_addr` out ADDR_WIDTH: memory address.
- `ram_select` out DATA_WIDTH/8: memory byte enables.
- `ram_data_o` out DATA_WIDTH: data to memory.
- `ram_data_i` in DATA_WIDTH: data from memory.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `m_req` is set, pick a winner by round-robin.
  - Latch the winner's index, addr, select, write_en and data into command registers.
  - Go to ISSUE.
- ISSUE:
  - `ram_en`=1 for exactly this cycle, driven from the command registers.
  - On a write, go to RESP.
  - On a read, load the counter with MEM_LATENCY-1 and go to WAIT.
- WAIT:
  - While the counter is nonzero, decrement it.
  - When the counter is zero, capture `ram_data_i` into the `m_data_o` register and go to RESP.
- RESP:
  - Pulse `m_ack[winner]`.
  - Update the round-robin pointer to the winner.
  - Return to IDLE.
- Round-robin rule: priority starts at the master after the last granted one, wrapping from NUM_MASTERS-1 to 0. After reset the pointer is NUM_MASTERS-1, so master 0 has highest priority.
- Masters hold their request fields stable from `m_req` rise until `m_ack`.
  - A master may keep `m_req` high in the ack cycle to request again.
  - That new request is arbitrated in the following IDLE cycle.
- `m_req` dropped before ack: the latched command still completes and ack is still pulsed. Masters must tolerate this.
- Write with `m_select`=0: issued normally and acked; memory modifies no bytes.
- `m_data_o` holds its last value outside ack cycles. Writes do not change it.
- `ram_addr`/`ram_select`/`ram_data_o`/`ram_write_en` are driven from the command registers. They are don't-care while `ram_en`=0, but must not change during ISSUE.

## Timing
- Reset values:
  - FSM = IDLE.
  - `ram_en`=0, `ram_write_en`=0, `m_ack`=0.
  - `m_data_o`=0, `ram_addr`=0, `ram_select`=0, `ram_data_o`=0.
  - Counter = 0, RR pointer = NUM_MASTERS-1.
- Let request seen in IDLE at cycle T:
  - ISSUE (`ram_en` high) is T+1.
  - Write ack is T+2.
  - Read data is sampled at T+1+MEM_LATENCY.
  - Read ack is T+2+MEM_LATENCY.
- Throughput:
  - One write per 3 cycles.
  - One read per MEM_LATENCY+3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait with no ack.
- Reset asserted mid-operation, in any state:
  - Next cycle is IDLE with all reset values.
  - No ack is issued for the aborted access.
  - `ram_en` is 0 in the cycle after reset.

## Structure
- FSM state encodings (2 bits) and the default width constants go in the shared `define.v`.
- Sub-module `rr_arbiter`:
  - Combinational one-hot grant from `req` and the `last` pointer.
  - Parametrised by NUM_MASTERS, with a binary index output.
- Counter width is $clog2(MEM_LATENCY+1).

## Test plan
- Single read: NUM_MASTERS=2, MEM_LATENCY=1. Master 0 reads 0x100 with memory returning 0xDEADBEEF → `ram_en` at T+1, `m_ack`=2'b01 and `m_data_o`=0xDEADBEEF at T+3.
- Write byte enables: master 1 writes 0x11223344 to 0x8, select 4'b0011 → `ram_write_en`=1, `ram_select`=0011 at T+1, `m_ack`=2'b10 at T+2, `m_data_o` unchanged.
- Contention: both masters hold `m_req` continuously for 4 writes → grant order 0,1,0,1, one ack every 3 cycles.
- Latency sweep: MEM_LATENCY=4, read → ack at T+6 carrying the data presented at T+5; data presented at T+4 is not taken.
- Reset in WAIT: assert `rst` for 1 cycle during WAIT → no ack, FSM IDLE, `ram_en`=0; master 0 wins the next simultaneous request.
- NUM_MASTERS=4, req=4'b1010 after master 3 was last granted → master 1 is granted, then master 3.
